i2c_slave_rx: RTL

Write-only I2C slave receiver that sits directly downstream of the team's `i2c` master on the shared SCL/SDA lines. It oversamples both lines with the system clock and detects START and STOP. It acknowledges its own 7-bit address with the write bit, then shifts in and acknowledges data bytes. Each received byte is presented as a parallel word with a one-cycle valid strobe.

---
 rtl/i2c_slave_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
//   Write-only I2C slave receiver. Oversamples SCL/SDA with clk, detects
//   START/STOP, ACKs its own 7-bit address with the write bit, then shifts in
//   and ACKs data bytes. Each complete byte is presented on rx_data with a
//   one-cycle rx_valid strobe.
//
// Parameters
//   SLAVE_ADDR  : 7-bit address acknowledged by this slave
//   SYNC_STAGES : synchronizer depth on scl/sda_in (2..3)
//
// Ports
//   clk        : system clock (single domain)
//   rst        : synchronous active-high reset
//   scl        : bus clock line (input only)
//   sda_in     : bus data line
//   sda_oe     : 1 = pull SDA low (ACK), 0 = release
//   rx_data    : last received data byte
//   rx_valid   : one-cycle pulse when rx_data updates
//   addr_match : high from address ACK until next STOP/START
//   busy       : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Front end: synchronizers (idle-high reset) plus one history flop
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_cur;
    logic sda_cur;
    logic scl_rise;
    logic scl_fall;
    logic start_evt;
    logic stop_evt;

    assign scl_cur  = scl_sync[SYNC_STAGES-1];
    assign sda_cur  = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl_cur & ~scl_prev;
    assign scl_fall = ~scl_cur &  scl_prev;
    // SCL must be high on both samples so an SDA edge that coincides with an
    // SCL edge is treated as a data transition, not a bus condition.
    assign start_evt = scl_cur & scl_prev &  sda_prev & ~sda_cur;
    assign stop_evt  = scl_cur & scl_prev & ~sda_prev &  sda_cur;

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    // The 3-bit counter wraps to 0 on the 8th bit, so this flag remembers
    // that a full byte is in the shifter until the SCL fall that opens the
    // ACK slot.
    logic       byte_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            byte_full  <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start_evt) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                byte_full  <= 1'b0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
            end else if (stop_evt) begin
                state      <= IDLE;
                bit_cnt    <= 3'd0;
                byte_full  <= 1'b0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_cur};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                byte_full <= 1'b1;
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            // Mismatched address or read request: stay off
                            // the bus (NACK) until the next bus condition.
                            if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                                sda_oe     <= 1'b1;
                                addr_match <= 1'b1;
                                state      <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_cur};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_full <= 1'b1;
                                rx_data   <= {shift[6:0], sda_cur};
                                rx_valid  <= 1'b1;
                            end
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= DATA_ACK;
                        end
                    end
                    default: ; // IDLE and WAIT_STOP leave only on start/stop
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
